// File: rtl/display_types_pkg.sv
// display_types: shared scan-state type, segment constants and hex decode table.
package display_types;
    typedef logic [3:0] logic4;
    typedef enum logic [1:0] {IDLE, DRIVE, BLANK} scan_state_t;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    // Active-low {dp,g,f,e,d,c,b,a}, dp off.
    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };
endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: combinational hex digit to active-low segment byte (dp bit off).
module hex_to_seg
    import display_types::*;
(
    input  logic4       hex,
    output logic [7:0]  seg
);
    assign seg = HEX_SEG[hex];
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed 8-digit seven-segment driver with per-frame snapshot
// and an all-off gap after every digit; outputs lag the scan state by one register.
module seven_seg_scanner
    import display_types::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DWELL_CYCLES = 2,
    parameter int BLANK_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic4       bcds [7:0],
    input  logic [7:0]  dp_mask,
    input  logic [7:0]  blank_mask,
    output logic [7:0]  sel_led,
    output logic [7:0]  led_value,
    output logic        frame_done
);
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int MAXC = DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

    scan_state_t   state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic4         digits_q [7:0];
    logic4         digits_d [7:0];
    logic [7:0]    dp_q, dp_d, blank_q, blank_d;
    logic [7:0]    sel_q, sel_d, led_q, led_d;
    logic          frame_q, frame_d;
    logic [7:0]    seg;
    logic          dwell_end, blank_end, advance, capture;

    hex_to_seg u_hex_to_seg (.hex(digits_q[idx_q]), .seg(seg));

    assign dwell_end = state_q == DRIVE && cnt_q == CW'(DWELL_CYCLES - 1);
    assign blank_end = state_q == BLANK && cnt_q == CW'(BLANK_CYCLES - 1);
    assign advance   = (dwell_end && BLANK_CYCLES == 0) || blank_end;
    assign capture   = enable && (state_q == IDLE || (advance && idx_q == LAST));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q + CW'(1);
        digits_d = digits_q;
        dp_d     = dp_q;
        blank_d  = blank_q;
        frame_d  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else if (capture) begin
            state_d  = DRIVE;
            idx_d    = '0;
            cnt_d    = '0;
            digits_d = bcds;
            dp_d     = dp_mask;
            blank_d  = blank_mask;
            frame_d  = 1'b1;
        end else if (advance) begin
            state_d = DRIVE;
            idx_d   = idx_q + IW'(1);
            cnt_d   = '0;
        end else if (dwell_end) begin
            state_d = BLANK;
            cnt_d   = '0;
        end
        // A falling enable darkens the display on the same edge the FSM drops to IDLE.
        sel_d = (!enable || state_q != DRIVE || blank_q[idx_q]) ? SEG_OFF : ~(8'(1) << idx_q);
        led_d = (!enable || state_q != DRIVE) ? SEG_OFF : {seg[7] & ~dp_q[idx_q], seg[6:0]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            digits_q <= '{default: '0};
            dp_q     <= '0;
            blank_q  <= '0;
            sel_q    <= SEG_OFF;
            led_q    <= SEG_OFF;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            dp_q     <= dp_d;
            blank_q  <= blank_d;
            sel_q    <= sel_d;
            led_q    <= led_d;
            frame_q  <= frame_d;
        end
    end

    assign sel_led    = sel_q;
    assign led_value  = led_q;
    assign frame_done = frame_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: decode table plus frame scoreboard for the default build and a no-gap build.
module tb_seven_seg_scanner;
    logic       clock = 1'b0;
    logic       reset, enable, enable2;
    logic [3:0] bcds [7:0];
    logic [7:0] dp_mask, blank_mask;
    logic [7:0] sel1, led1, sel2, led2;
    logic       fd1, fd2;

    always #5 clock = ~clock;

    seven_seg_scanner dut (
        .clock(clock), .reset(reset), .enable(enable), .bcds(bcds),
        .dp_mask(dp_mask), .blank_mask(blank_mask),
        .sel_led(sel1), .led_value(led1), .frame_done(fd1)
    );

    seven_seg_scanner #(.BLANK_CYCLES(0)) dut_nogap (
        .clock(clock), .reset(reset), .enable(enable2), .bcds(bcds),
        .dp_mask(dp_mask), .blank_mask(blank_mask),
        .sel_led(sel2), .led_value(led2), .frame_done(fd2)
    );

    typedef struct {
        logic [3:0] hex;
        logic [7:0] seg;
    } vec_t;

    typedef struct {
        logic [7:0] sel;
        logic [7:0] led;
        logic       fd;
    } exp_t;

    vec_t       tbl [16];
    exp_t       q [$];
    logic [3:0] m_bcds [8];
    logic [7:0] m_dp, m_bm;
    int         checks = 0;
    int         errors = 0;
    bit         cur = 1'b0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] seg_of(input logic [3:0] h);
        logic [7:0] s = 8'hFF;
        for (int i = 0; i < 16; i++) if (tbl[i].hex == h) s = tbl[i].seg;
        return s;
    endfunction

    function automatic logic [7:0] a_sel();
        return cur ? sel2 : sel1;
    endfunction

    function automatic logic [7:0] a_led();
        return cur ? led2 : led1;
    endfunction

    function automatic logic a_fd();
        return cur ? fd2 : fd1;
    endfunction

    task automatic push_frame(input int dw, input int bl, input bit fd_end);
        exp_t       e;
        logic [7:0] one = 8'h01;
        logic [7:0] s;
        for (int i = 0; i < 8; i++) begin
            for (int p = 0; p < dw + bl; p++) begin
                s     = seg_of(m_bcds[i]);
                e.sel = (p < dw && !m_bm[i]) ? ~(one << i) : 8'hFF;
                e.led = (p < dw) ? {~m_dp[i], s[6:0]} : 8'hFF;
                e.fd  = fd_end && i == 7 && p == dw + bl - 1;
                q.push_back(e);
            end
        end
    endtask

    task automatic run(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            tick();
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard empty at %0t", $time);
            end else begin
                e = q.pop_front();
                chk("sel_led", a_sel(), e.sel);
                chk("led_value", a_led(), e.led);
                chk("frame_done", {7'b0, a_fd()}, {7'b0, e.fd});
            end
        end
    endtask

    task automatic set_en(input logic v);
        if (cur) enable2 = v;
        else enable = v;
    endtask

    task automatic start();
        q.delete();
        for (int i = 0; i < 8; i++) m_bcds[i] = bcds[i];
        m_dp = dp_mask;
        m_bm = blank_mask;
        set_en(1'b0);
        tick();
        chk("idle sel", a_sel(), 8'hFF);
        chk("idle led", a_led(), 8'hFF);
        set_en(1'b1);
        tick();
        chk("start frame_done", {7'b0, a_fd()}, 8'h01);
        chk("start sel", a_sel(), 8'hFF);
    endtask

    initial begin
        tbl = '{'{4'h0, 8'hC0}, '{4'h1, 8'hF9}, '{4'h2, 8'hA4}, '{4'h3, 8'hB0},
                '{4'h4, 8'h99}, '{4'h5, 8'h92}, '{4'h6, 8'h82}, '{4'h7, 8'hF8},
                '{4'h8, 8'h80}, '{4'h9, 8'h90}, '{4'hA, 8'h88}, '{4'hB, 8'h83},
                '{4'hC, 8'hC6}, '{4'hD, 8'hA1}, '{4'hE, 8'h86}, '{4'hF, 8'h8E}};
        reset = 1'b1;
        enable = 1'b1;
        enable2 = 1'b0;
        dp_mask = 8'h00;
        blank_mask = 8'h00;
        for (int i = 0; i < 8; i++) bcds[i] = 4'h5;
        repeat (3) begin
            tick();
            chk("reset sel", sel1, 8'hFF);
            chk("reset led", led1, 8'hFF);
            chk("reset fd", {7'b0, fd1}, 8'h00);
            chk("reset fd nogap", {7'b0, fd2}, 8'h00);
        end
        reset = 1'b0;
        tick();
        chk("first fd", {7'b0, fd1}, 8'h01);
        chk("first sel", sel1, 8'hFF);
        for (int i = 0; i < 8; i++) m_bcds[i] = 4'h5;
        m_dp = 8'h00;
        m_bm = 8'h00;
        push_frame(2, 1, 1'b1);
        run(24);

        for (int i = 0; i < 8; i++) bcds[i] = 4'(i);
        start();
        push_frame(2, 1, 1'b1);
        push_frame(2, 1, 1'b1);
        run(48);

        for (int i = 0; i < 8; i++) bcds[i] = 4'(8 + i);
        start();
        push_frame(2, 1, 1'b1);
        run(24);

        for (int i = 0; i < 7; i++) bcds[i] = 4'(i);
        bcds[7] = 4'h0;
        start();
        push_frame(2, 1, 1'b1);
        run(9);
        bcds[7] = 4'hF;
        run(15);
        m_bcds[7] = 4'hF;
        push_frame(2, 1, 1'b1);
        run(24);

        bcds[0] = 4'h0;
        dp_mask = 8'h01;
        blank_mask = 8'h80;
        start();
        push_frame(2, 1, 1'b1);
        run(24);
        dp_mask = 8'h00;
        blank_mask = 8'h00;

        for (int i = 0; i < 8; i++) bcds[i] = 4'(i);
        start();
        push_frame(2, 1, 1'b1);
        run(13);
        enable = 1'b0;
        tick();
        chk("drop sel", sel1, 8'hFF);
        chk("drop led", led1, 8'hFF);
        chk("drop fd", {7'b0, fd1}, 8'h00);
        q.delete();
        tick();
        chk("idle hold sel", sel1, 8'hFF);
        enable = 1'b1;
        tick();
        chk("restart fd", {7'b0, fd1}, 8'h01);
        push_frame(2, 1, 1'b1);
        run(23);
        enable = 1'b0;
        tick();
        chk("wrap drop fd", {7'b0, fd1}, 8'h00);
        chk("wrap drop sel", sel1, 8'hFF);
        q.delete();
        tick();
        chk("wrap drop idle led", led1, 8'hFF);

        cur = 1'b1;
        start();
        push_frame(2, 0, 1'b1);
        push_frame(2, 0, 1'b1);
        run(32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Time-multiplexed 8-digit seven-segment driver on the FPGA top level. It is the stage downstream of the CPU/debug-mux logic.
- Consumes the 8-entry 4-bit hex digit array (PC and debug word) and drives active-low anode selects and segment lines.
- Snapshots the digit array once per frame to prevent tearing. Inserts a blanking gap between digits to suppress ghosting.
- Runs on the slow display clock (5 kHz domain).

Parameters:
- NUM_DIGITS, 8, number of digits scanned; fixed at 8 in this revision, widths below assume it.
- DWELL_CYCLES, 2, clock cycles each digit is driven; must be >= 1.
- BLANK_CYCLES, 1, all-off cycles after each digit; 0 permitted (no gap).

Ports:
- clock, input, 1, display clock.
- reset, input, 1, synchronous, active-high.
- enable, input, 1, 1 = scan; 0 = display dark.
- bcds, input, 8x4 (unpacked [7:0] of logic4), hex digit per position; index 7 = leftmost.
- dp_mask, input, 8, 1 = light the decimal point of that digit.
- blank_mask, input, 8, 1 = force that digit dark (anode stays off).
- sel_led, output, 8, active-low anode select; bit i = digit i.
- led_value, output, 8, active-low segments {dp,g,f,e,d,c,b,a}.
- frame_done, output, 1, single-cycle pulse when a new frame snapshot is taken.

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high; the port names are clock and reset.
  - Reset values: sel_led=8'hFF, led_value=8'hFF, frame_done=0, state=IDLE, digit index=0, snapshot registers=0.
  - All outputs are registered. No combinational path from inputs to outputs.
- States:
  - IDLE: outputs FF/FF.
    - If enable=1 at an edge: capture snapshot (bcds, dp_mask, blank_mask), idx<=0, dwell counter<=0, enter DRIVE, drive digit 0, frame_done<=1 for that cycle.
    - The first lit cycle is therefore 1 cycle after enable is sampled high.
  - DRIVE: sel_led = ~(1<<idx), unless snapshot blank_mask[idx]=1, in which case sel_led=FF.
    - led_value = {~dp_mask[idx], hex decode of snapshot digit idx}.
    - Stay DWELL_CYCLES cycles, then:
      - If BLANK_CYCLES>0: enter BLANK.
      - If BLANK_CYCLES=0: advance directly (same rules as the BLANK exit).
  - BLANK: outputs FF/FF for BLANK_CYCLES cycles, then advance:
    - If idx<7: idx<=idx+1, enter DRIVE.
    - If idx==7: idx<=0, re-capture snapshot, frame_done<=1 for that one cycle, enter DRIVE.
- Frame length: 8*(DWELL_CYCLES+BLANK_CYCLES) cycles. With defaults this is 24 cycles, about 208 Hz at 5 kHz.
- enable falls in any state: the next edge enters IDLE with outputs FF/FF and idx=0. A later enable restarts at digit 0 with a fresh snapshot.
- Simultaneous: if enable falls on the same edge as a frame wrap, IDLE wins and frame_done stays 0.
- Input changes mid-frame have no visible effect until the next snapshot.
- Hex decode, active-low {g..a} with dp off shown as full byte:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - The dp bit (bit 7) is cleared when dp_mask is set.
- Counter widths: idx 3 bits. Dwell/blank counter is $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1) bits. The counter resets to 0 on every state entry.

Decomposition:
- Shared package display_types:
  - logic4 reuse (from global_types).
  - typedef enum {IDLE, DRIVE, BLANK} scan_state_t.
  - constant SEG_OFF=8'hFF.
  - constant array HEX_SEG[16] holding the decode table above.
- Sub-module hex_to_seg: combinational 4-bit to 7-segment decoder using HEX_SEG. Instantiated once, fed by the snapshot digit at idx.

Test Plan:
- Reset held 3 cycles with enable=1 and bcds all 5 -> sel_led=FF, led_value=FF, frame_done=0 throughout. First edge after release gives frame_done=1; the following cycle gives sel_led=FE, led_value=92.
- bcds[i]=i for i=0..7, dp_mask=0, blank_mask=0, defaults -> per digit i: 2 cycles of sel_led=~(1<<i) with the correct table code, then 1 cycle FF/FF. frame_done pulses every 24 cycles.
- Repeat with bcds[i]=8+i -> codes 80, 90, 88, 83, C6, A1, 86, 8E in order; all 16 codes covered across the two tests.
- Change bcds[7] from 0 to F while idx=3 -> digit 7 shows C0 this frame and 8E only in the next frame.
- dp_mask=8'h01, blank_mask=8'h80, bcds[0]=0 -> digit 0 led_value=40. The digit-7 slot keeps sel_led=FF for its 2 dwell cycles, with frame timing unchanged.
- Drop enable while idx=4 (DRIVE) -> next cycle FF/FF and IDLE. Re-raise enable -> frame_done pulse, then digit 0 resumes. BLANK_CYCLES=0 build: no FF gap, frame=16 cycles.
